// File: rtl/vga_vram_arbiter_pkg.sv
// Shared VGA timing constants and types for the VRAM arbiter slice.
package vga_vram_arbiter_pkg;

  // 640x480@60 timing, pixel-clock units
  localparam int VGA_TOTAL_COLS  = 800;
  localparam int VGA_TOTAL_ROWS  = 525;
  localparam int VGA_ACTIVE_COLS = 640;
  localparam int VGA_ACTIVE_ROWS = 480;
  localparam int VGA_H_FP        = 16;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BP        = 48;
  localparam int VGA_V_FP        = 10;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BP        = 33;

  // 8x8 pixel cells, 80x60 of them
  localparam int CELL_SHIFT = 3;
  localparam int CELLS_X    = 80;
  localparam int CELLS_Y    = 60;

  localparam int VGA_ADDR_W = 13;
  localparam int VGA_DATA_W = 8;

  typedef logic [VGA_ADDR_W-1:0] cell_addr_t;

  // which host port wins the next tie
  typedef enum logic {RR_WRITE = 1'b0, RR_READ = 1'b1} rr_t;

endpackage

// File: rtl/vga_vram_arbiter_rr.sv
// Two-way round-robin between host write (bit 0) and host read (bit 1).
// inhibit blocks both ports without moving the pointer.
module rr_arbiter2
  import vga_vram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inhibit,
  input  logic [1:0] req,
  output logic [1:0] rdy,
  output logic [1:0] gnt
);

  rr_t ptr;

  // A port is ready unless the other one is also asking and owns the tie.
  assign rdy[0] = !inhibit && (!req[1] || ptr == RR_WRITE);
  assign rdy[1] = !inhibit && (!req[0] || ptr == RR_READ);
  assign gnt    = req & rdy;

  // Pointer hands priority to the other port after every grant.
  always_ff @(posedge clk) begin
    if (!rst_n)      ptr <= RR_WRITE;
    else if (gnt[0]) ptr <= RR_READ;
    else if (gnt[1]) ptr <= RR_WRITE;
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM scheduler: display fetch owns one slot per 8-pixel cell,
// host write/read share every other cycle round-robin.
module vga_vram_arbiter
  import vga_vram_arbiter_pkg::*;
#(
  parameter int TOTAL_COLS  = VGA_TOTAL_COLS,
  parameter int TOTAL_ROWS  = VGA_TOTAL_ROWS,
  parameter int ACTIVE_COLS = VGA_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = VGA_ACTIVE_ROWS,
  parameter int ADDR_W      = VGA_ADDR_W,
  parameter int DATA_W      = VGA_DATA_W
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        row,
  input  logic [9:0]        col,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Fetch two pixels ahead: one cycle of RAM latency, one of pix_data register.
  logic [10:0] col2, row1;
  logic        wrap;
  logic [9:0]  tc, tr;

  assign col2 = {1'b0, col} + 11'd2;
  assign wrap = col2 >= 11'(TOTAL_COLS);
  assign tc   = wrap ? 10'(col2 - 11'(TOTAL_COLS)) : col2[9:0];
  assign row1 = {1'b0, row} + {10'd0, wrap};
  assign tr   = (row1 == 11'(TOTAL_ROWS)) ? 10'd0 : row1[9:0];

  logic slot;
  assign slot = (tc[CELL_SHIFT-1:0] == '0) && (tc < 10'(ACTIVE_COLS)) &&
                (tr < 10'(ACTIVE_ROWS));

  // cell_y*80 as shift-add (CELLS_X = 64 + 16)
  logic [ADDR_W-1:0] cy, cx, disp_addr;
  assign cy        = ADDR_W'(tr >> CELL_SHIFT);
  assign cx        = ADDR_W'(tc >> CELL_SHIFT);
  assign disp_addr = (cy << 6) + (cy << 4) + cx;

  logic [1:0] rdy, gnt;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inhibit (slot),
    .req     ({rd_valid, wr_valid}),
    .rdy     (rdy),
    .gnt     (gnt)
  );

  assign wr_ready  = rdy[0];
  assign rd_ready  = rdy[1];
  assign pix_valid = (row < 10'(ACTIVE_ROWS)) && (col < 10'(ACTIVE_COLS));

  // RAM port mux: display slot first, then whichever host port was granted.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (slot) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (gnt[1]) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end
  end

  // [0] read issued last cycle, [1] response presented this cycle
  logic [1:0] rd_vld_pipe;
  logic       disp_pend;

  assign rd_resp_valid = rd_vld_pipe[1];

  // Capture RAM data one cycle after issue into pixel or read-response register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_pend    <= 1'b0;
      rd_vld_pipe  <= '0;
      pix_data     <= '0;
      rd_resp_data <= '0;
    end else begin
      disp_pend   <= slot;
      rd_vld_pipe <= {rd_vld_pipe[0], gnt[1]};
      if (disp_pend)      pix_data     <= mem_rdata;
      if (rd_vld_pipe[0]) rd_resp_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench: random host traffic over a scanned raster, checked
// against a linear-position timing model and a shadow copy of VRAM.
module tb_vga_vram_arbiter;

  localparam int TC = 800, TR = 525, AC = 640, AR = 480;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  row, col;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        wr_valid, wr_ready;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_valid, rd_ready;
  logic [12:0] rd_addr;
  logic        rd_resp_valid;
  logic [7:0]  rd_resp_data;
  logic        mem_en, mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  vga_vram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // synchronous single-port VRAM, read data valid the cycle after issue
  logic [7:0] vram   [0:8191];
  logic [7:0] shadow [0:8191];
  logic [7:0] rdata_q = 8'h00;
  assign mem_rdata = rdata_q;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      vram[i]   = 8'($urandom);
      shadow[i] = vram[i];
    end
    vram[0]   = 8'hA5; shadow[0]   = 8'hA5;
    vram[100] = 8'h3C; shadow[100] = 8'h3C;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else        rdata_q        <= vram[mem_addr];
    end
  end

  // scoreboard state
  typedef struct { logic [7:0] d; int c; } rsp_t;
  rsp_t       rq[$];
  logic [7:0] pq[$];
  rsp_t       r;
  logic [7:0] cur_pix;
  bit         ptr_w;
  bit         pix_chk_en;
  bit         wr_acc, rd_acc;
  int         cyc, rst_cnt;
  int         n_chk, n_pass;
  int         mp, mt, mtr, mtc, maddr;
  bit         mslot, mgw, mgr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  // monitor: evaluate the reference model for the cycle now on the pins
  always @(negedge clk) begin
    cyc++;
    wr_acc = wr_valid && wr_ready;
    rd_acc = rd_valid && rd_ready;
    if (!rst_n) begin
      ptr_w = 1'b1;
      rq.delete();
      pq.delete();
      if (rst_cnt > 0) begin
        chk("rst_rd_resp_valid", rd_resp_valid, 0);
        chk("rst_rd_resp_data",  rd_resp_data,  0);
        chk("rst_pix_data",      pix_data,      0);
      end
      rst_cnt++;
    end else begin
      mp    = int'(row) * TC + int'(col);
      mt    = (mp + 2) % (TC * TR);
      mtr   = mt / TC;
      mtc   = mt % TC;
      mslot = (mtc % 8 == 0) && (mtc < AC) && (mtr < AR);
      maddr = (mtr / 8) * 80 + mtc / 8;
      mgw   = !mslot && wr_valid && (!rd_valid || ptr_w);
      mgr   = !mslot && rd_valid && (!wr_valid || !ptr_w);

      chk("wr_grant", wr_acc, mgw);
      chk("rd_grant", rd_acc, mgr);
      chk("mem_en", mem_en, mslot || mgw || mgr);
      if (mslot) begin
        chk("slot_wr_ready", wr_ready, 0);
        chk("slot_rd_ready", rd_ready, 0);
        chk("disp_we",   mem_we,   0);
        chk("disp_addr", mem_addr, maddr);
        if (pix_chk_en) pq.push_back(shadow[maddr]);
      end else if (mgw) begin
        chk("wr_we",    mem_we,    1);
        chk("wr_addr",  mem_addr,  wr_addr);
        chk("wr_wdata", mem_wdata, wr_data);
        shadow[wr_addr] = wr_data;
        ptr_w = 1'b0;
      end else if (mgr) begin
        chk("rd_we",   mem_we,   0);
        chk("rd_addr", mem_addr, rd_addr);
        rq.push_back('{shadow[rd_addr], cyc + 2});
        ptr_w = 1'b1;
      end else begin
        chk("idle_we", mem_we, 0);
      end

      if (rd_resp_valid) begin
        if (rq.size() == 0) chk("rd_resp_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          chk("rd_resp_data",    rd_resp_data, r.d);
          chk("rd_resp_latency", cyc,          r.c);
        end
      end else if (rq.size() > 0) begin
        if (rq[0].c <= cyc) begin
          chk("rd_resp_missing", 0, 1);
          void'(rq.pop_front());
        end
      end

      chk("pix_valid", pix_valid, (row < AR) && (col < AC));
      if (pix_chk_en && row < AR && col < AC) begin
        if (col % 8 == 0) begin
          if (pq.size() == 0) chk("pix_fetch_missing", 0, 1);
          else cur_pix = pq.pop_front();
        end
        chk("pix_data", pix_data, cur_pix);
      end
    end
  end

  // stimulus helpers
  task automatic host_update(input int wp, input int rp);
    if (!wr_valid || wr_acc) begin
      wr_valid = ($urandom_range(99) < wp);
      wr_addr  = 13'($urandom_range(4799));
      wr_data  = 8'($urandom);
    end
    if (!rd_valid || rd_acc) begin
      rd_valid = ($urandom_range(99) < rp);
      rd_addr  = 13'($urandom_range(4799));
    end
  endtask

  task automatic adv();
    if (col == 10'(TC - 1)) begin
      col = 10'd0;
      row = (row == 10'(TR - 1)) ? 10'd0 : row + 10'd1;
    end else col = col + 10'd1;
  endtask

  task automatic run_scan(input int n, input int wp, input int rp);
    repeat (n) begin
      @(posedge clk); #1;
      adv();
      host_update(wp, rp);
    end
  endtask

  task automatic jump(input int r0, input int c0);
    @(posedge clk); #1;
    row = 10'(r0);
    col = 10'(c0);
    pq.delete();
    host_update(30, 30);
  endtask

  int pr[7] = '{524, 479, 10, 9, 0, 523, 300};
  int pc[7] = '{798, 638, 798, 14, 6, 799, 5};

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; rst_cnt = 0;
    pix_chk_en = 1'b0; cur_pix = 8'h00; ptr_w = 1'b1;
    rst_n = 1'b0; row = 10'd524; col = 10'd700;
    wr_valid = 1'b1; wr_addr = 13'd4000; wr_data = 8'h00;
    rd_valid = 1'b1; rd_addr = 13'd100;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; pix_chk_en = 1'b1;

    // rows 0..9 plus the wrap from the last blank line
    run_scan(100 + 10 * 800 + 700, 30, 30);
    // bottom edge of the active area into vertical blanking
    jump(478, 700);
    run_scan(2 * 800 + 100, 30, 30);
    // blanking contention: both ports always asking
    jump(500, 0);
    run_scan(16, 100, 100);

    // isolated raster points, pixel tracking off
    pix_chk_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      row = 10'(pr[i]); col = 10'(pc[i]);
      host_update(60, 60);
    end
    // a write held across the col 6 slot goes out at col 7
    wait (!wr_valid || wr_acc);
    @(posedge clk); #1;
    row = 10'd0; col = 10'd6;
    wr_valid = 1'b1; wr_addr = 13'd200; wr_data = 8'h5A; rd_valid = 1'b0;
    @(posedge clk); #1;
    col = 10'd7;
    @(posedge clk); #1;
    row = 10'd500; col = 10'd0;
    if (wr_acc) wr_valid = 1'b0;
    // back-to-back reads in blanking
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      col = col + 10'd1;
      if (wr_acc) wr_valid = 1'b0;
      rd_valid = 1'b1;
      rd_addr  = (i == 0) ? 13'd100 : (i == 1) ? 13'd200 : 13'd0;
    end

    // frame wrap with pixel tracking back on
    @(posedge clk); #1;
    pix_chk_en = 1'b1;
    row = 10'd523; col = 10'd700;
    pq.delete();
    host_update(30, 30);
    run_scan(1800, 30, 30);
    run_scan(6, 0, 0);

    chk("rd_queue_empty", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
